// File: rtl/bram_cam_pkg.sv
// cam_pkg: shared FSM state type and sizing helpers for the bram_cam lookup engine.
package cam_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ERASE,
    WRITE
  } cam_state_e;

  // Number of slice RAMs needed to cover the key; the top slice is zero-padded.
  function automatic int cam_num_slices(input int data_w, input int slice_w);
    return (data_w + slice_w - 1) / slice_w;
  endfunction

  // INIT clears one slice-RAM row per cycle, so its length equals the row count.
  function automatic int cam_init_len(input int slice_w);
    return 1 << slice_w;
  endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// cam_priority_encoder: isolates the lowest set bit of a request vector,
// encodes its index and flags whether any bit was set.
module cam_priority_encoder #(
  parameter int WIDTH = 32,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] onehot,
  output logic [IW-1:0]    index,
  output logic             valid
);

  // Two's-complement trick keeps the lowest bit; the downward scan leaves the lowest index last.
  always_comb begin
    onehot = req & (~req + WIDTH'(1));
    index  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) index = IW'(i);
    end
    valid = |req;
  end

endmodule

// File: rtl/bram_cam.sv
// bram_cam: binary CAM built from slice RAMs. Each key slice addresses a row
// holding one match bit per entry; ANDing the rows read for every slice gives
// match_many. Optional macro CAM_PRIORITY_ENC_EN adds the lowest-match encoder
// driving match_single/match_addr; when undefined both are tied to 0.
module bram_cam
  import cam_pkg::*;
#(
  parameter int    DATA_WIDTH  = 64,
  parameter int    ADDR_WIDTH  = 5,
  parameter string CAM_STYLE   = "BRAM",
  parameter int    SLICE_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      write_addr,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic                       write_delete,
  input  logic                       write_enable,
  input  logic [DATA_WIDTH-1:0]      compare_data,
  output logic                       write_busy,
  output logic [(2**ADDR_WIDTH)-1:0] match_many,
  output logic [(2**ADDR_WIDTH)-1:0] match_single,
  output logic [ADDR_WIDTH-1:0]      match_addr,
  output logic                       match
);

  localparam int NS    = cam_num_slices(DATA_WIDTH, SLICE_WIDTH);
  localparam int PAD_W = NS * SLICE_WIDTH;
  localparam int NENT  = 2 ** ADDR_WIDTH;
  localparam int ROWS  = cam_init_len(SLICE_WIDTH);

  if (CAM_STYLE != "BRAM") begin : g_style_check
    $error("bram_cam: only the BRAM storage style is supported");
  end

  function automatic logic [PAD_W-1:0] pad_key(input logic [DATA_WIDTH-1:0] key);
    return PAD_W'(key);
  endfunction

  cam_state_e               state, state_nxt;
  logic [SLICE_WIDTH-1:0]   init_row;
  logic [NENT-1:0]          valid_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic                     wr_del_q;
  logic                     init_clr, do_erase, do_write;
  logic [DATA_WIDTH-1:0]    shadow_key [NENT];
  logic [NENT-1:0]          slice_ram [NS][ROWS];
  logic [PAD_W-1:0]         old_pad, new_pad;
  logic [PAD_W-1:0]         key_p0;
  logic                     vld_p0, vld_p1;
  logic [NENT-1:0]          rd_p1 [NS];
  logic [NENT-1:0]          many_c, single_c;
  logic [ADDR_WIDTH-1:0]    addr_c;

  assign old_pad = pad_key(shadow_key[wr_addr_q]);
  assign new_pad = pad_key(wr_data_q);

  // State register; reset restarts INIT from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (init_row == SLICE_WIDTH'(ROWS - 1)) state_nxt = IDLE;
      IDLE:    if (write_enable) state_nxt = ERASE;
      ERASE:   state_nxt = wr_del_q ? IDLE : WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // FSM outputs: busy flag and the single-cycle storage update strobes.
  always_comb begin
    write_busy = (state != IDLE);
    init_clr   = (state == INIT);
    do_erase   = (state == ERASE) && valid_q[wr_addr_q];
    do_write   = (state == WRITE);
  end

  // Control state: INIT row counter, entry valid bits and compare valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_row <= '0;
      valid_q  <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p0 <= (state != INIT);
      vld_p1 <= vld_p0 && (state != INIT);
      if (state == INIT) begin
        init_row <= init_row + 1'b1;
        valid_q  <= '0;
      end else if (state == ERASE) begin
        valid_q[wr_addr_q] <= 1'b0;
      end else if (state == WRITE) begin
        valid_q[wr_addr_q] <= 1'b1;
      end
    end
  end

  // Latch the accepted write request; requests arriving while busy are dropped.
  always_ff @(posedge clk) begin
    if (state == IDLE && write_enable) begin
      wr_addr_q <= write_addr;
      wr_data_q <= write_data;
      wr_del_q  <= write_delete;
    end
  end

  // Shadow copy of each stored key, needed to find the rows to erase.
  always_ff @(posedge clk) begin
    if (do_write) shadow_key[wr_addr_q] <= wr_data_q;
  end

  // Slice RAMs: row clear in INIT, single-bit erase/set otherwise, registered compare read.
  always_ff @(posedge clk) begin
    // p0: sample compare key
    key_p0 <= pad_key(compare_data);
    for (int s = 0; s < NS; s++) begin
      if (init_clr)
        slice_ram[s][init_row] <= '0;
      else if (do_erase)
        slice_ram[s][old_pad[s*SLICE_WIDTH +: SLICE_WIDTH]][wr_addr_q] <= 1'b0;
      else if (do_write)
        slice_ram[s][new_pad[s*SLICE_WIDTH +: SLICE_WIDTH]][wr_addr_q] <= 1'b1;
      // p1: slice rows read
      rd_p1[s] <= slice_ram[s][key_p0[s*SLICE_WIDTH +: SLICE_WIDTH]];
    end
  end

  // An entry matches only when every slice row agrees.
  always_comb begin
    many_c = '1;
    for (int s = 0; s < NS; s++) many_c &= rd_p1[s];
  end

`ifdef CAM_PRIORITY_ENC_EN
  logic [NENT-1:0]       enc_onehot;
  logic [ADDR_WIDTH-1:0] enc_index;
  logic                  enc_valid;

  cam_priority_encoder #(
    .WIDTH (NENT),
    .IW    (ADDR_WIDTH)
  ) u_prio (
    .req    (many_c),
    .onehot (enc_onehot),
    .index  (enc_index),
    .valid  (enc_valid)
  );

  assign single_c = enc_valid ? enc_onehot : '0;
  assign addr_c   = enc_valid ? enc_index  : '0;
`else
  assign single_c = '0;
  assign addr_c   = '0;
`endif

  // p2: registered match outputs, forced to 0 while INIT runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_many   <= '0;
      match_single <= '0;
      match_addr   <= '0;
      match        <= 1'b0;
    end else if (vld_p1 && state != INIT) begin
      match_many   <= many_c;
      match_single <= single_c;
      match_addr   <= addr_c;
      match        <= |many_c;
    end else begin
      match_many   <= '0;
      match_single <= '0;
      match_addr   <= '0;
      match        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_cam.sv
// tb_bram_cam: directed bench for bram_cam with an entry-level reference model
// (key/valid arrays) checked every meaningful cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_bram_cam;

  localparam int DW = 24;
  localparam int AW = 9;
  localparam int SW = 8;
  localparam int NE = 512;
`ifdef CAM_PRIORITY_ENC_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_delete = 1'b0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] compare_data = '0;
  logic          write_busy;
  logic [NE-1:0] match_many;
  logic [NE-1:0] match_single;
  logic [AW-1:0] match_addr;
  logic          match;

  always #5 clk = ~clk;

  bram_cam #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CAM_STYLE   ("BRAM"),
    .SLICE_WIDTH (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_delete (write_delete),
    .write_enable (write_enable),
    .compare_data (compare_data),
    .write_busy   (write_busy),
    .match_many   (match_many),
    .match_single (match_single),
    .match_addr   (match_addr),
    .match        (match)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each address currently holds.
  logic [DW-1:0] mdl_key [NE];
  bit            mdl_vld [NE];

  function automatic logic [NE-1:0] mdl_many(input logic [DW-1:0] k);
    logic [NE-1:0] r;
    r = '0;
    for (int i = 0; i < NE; i++) if (mdl_vld[i] && mdl_key[i] == k) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int low_idx(input logic [NE-1:0] v);
    for (int i = 0; i < NE; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [NE-1:0] exp_single(input logic [NE-1:0] v);
    logic [NE-1:0] r;
    r = '0;
    if (PE && v != '0) r[low_idx(v)] = 1'b1;
    return r;
  endfunction

  function automatic logic [NE-1:0] exp_addr(input logic [NE-1:0] v);
    return PE ? NE'(low_idx(v)) : '0;
  endfunction

  task automatic chk(input string nm, input logic [NE-1:0] act, input logic [NE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle check: a compare is meaningful if the CAM stayed idle and out of
  // reset across its sampling edge and both pipeline edges after it.
  bit            h_en  [3];
  logic [NE-1:0] h_exp [3];

  always @(posedge clk) begin
    bit ok;
    ok = rst && !write_busy;
    h_en[2]  = h_en[1] && ok;
    h_exp[2] = h_exp[1];
    h_en[1]  = h_en[0] && ok;
    h_exp[1] = h_exp[0];
    h_en[0]  = ok;
    h_exp[0] = mdl_many(compare_data);
  end

  always @(negedge clk) begin
    if (h_en[2]) begin
      chk("cyc_many",   match_many,       h_exp[2]);
      chk("cyc_match",  NE'(match),       NE'(|h_exp[2]));
      chk("cyc_single", match_single,     exp_single(h_exp[2]));
      chk("cyc_addr",   NE'(match_addr),  exp_addr(h_exp[2]));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (write_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", NE'(write_busy), NE'(0));
  endtask

  task automatic reset_and_init(input string nm);
    int n;
    bit nz;
    rst = 1'b0;
    foreach (mdl_vld[i]) mdl_vld[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_rst_busy"}, NE'(write_busy), NE'(1));
    chk({nm, "_rst_outs"}, match_many | match_single | NE'(match_addr) | NE'(match), '0);
    rst = 1'b1;
    n  = 0;
    nz = 1'b0;
    while (write_busy && n < 1000) begin
      if (match || match_many != '0 || match_single != '0 || match_addr != '0) nz = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({nm, "_init_len"},  NE'(n),  NE'(256));
    chk({nm, "_init_zero"}, NE'(nz), NE'(0));
  endtask

  task automatic cam_write(input int a, input logic [DW-1:0] d, input bit del, input bit measure);
    int n;
    wait_idle();
    write_addr   = AW'(a);
    write_data   = d;
    write_delete = del;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    if (del) mdl_vld[a] = 1'b0;
    else begin
      mdl_vld[a] = 1'b1;
      mdl_key[a] = d;
    end
    if (measure) begin
      n = 0;
      while (write_busy && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk(del ? "del_busy_len" : "wr_busy_len", NE'(n), NE'(del ? 1 : 2));
    end
  endtask

  task automatic cam_cmp(input logic [DW-1:0] k);
    wait_idle();
    compare_data = k;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [NE-1:0] e;

    reset_and_init("init1");
    cam_cmp(24'h000000);
    chk("empty_match", NE'(match), NE'(0));

    cam_write(5, 24'hABCDEF, 1'b0, 1'b1);
    cam_cmp(24'hABCDEF);
    e = NE'(1) << 5;
    chk("a5_match",  NE'(match),      NE'(1));
    chk("a5_many",   match_many,      e);
    chk("a5_single", match_single,    PE ? e : '0);
    chk("a5_addr",   NE'(match_addr), PE ? NE'(5) : '0);

    cam_write(7,   24'h123456, 1'b0, 1'b1);
    cam_write(300, 24'h123456, 1'b0, 1'b1);
    cam_cmp(24'h123456);
    chk("dup_many",   match_many,      (NE'(1) << 7) | (NE'(1) << 300));
    chk("dup_single", match_single,    PE ? (NE'(1) << 7) : '0);
    chk("dup_addr",   NE'(match_addr), PE ? NE'(7) : '0);

    cam_write(5, 24'h111111, 1'b0, 1'b1);
    cam_cmp(24'hABCDEF);
    chk("ovw_old_match", NE'(match), NE'(0));
    chk("ovw_old_many",  match_many, '0);
    cam_cmp(24'h111111);
    chk("ovw_new_match", NE'(match),      NE'(1));
    chk("ovw_new_addr",  NE'(match_addr), PE ? NE'(5) : '0);

    cam_write(5, 24'h111111, 1'b0, 1'b1);
    cam_cmp(24'h111111);
    chk("same_rewrite_many", match_many, NE'(1) << 5);

    cam_write(7, 24'h000000, 1'b1, 1'b1);
    cam_cmp(24'h123456);
    chk("del7_many", match_many,      NE'(1) << 300);
    chk("del7_addr", NE'(match_addr), PE ? NE'(300) : '0);
    cam_write(300, 24'h000000, 1'b1, 1'b1);
    cam_cmp(24'h123456);
    chk("del300_match", NE'(match), NE'(0));
    cam_write(300, 24'h000000, 1'b1, 1'b1);
    cam_cmp(24'h123456);
    chk("del_invalid_match", NE'(match), NE'(0));

    // Second request while busy must be dropped.
    cam_write(20, 24'h5A5A5A, 1'b0, 1'b0);
    write_addr   = AW'(21);
    write_data   = 24'hC3C3C3;
    write_delete = 1'b0;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    cam_cmp(24'hC3C3C3);
    chk("busy_ignored_match", NE'(match), NE'(0));
    cam_cmp(24'h5A5A5A);
    chk("busy_first_many", match_many, NE'(1) << 20);

    // Reset in the middle of a write wipes every entry.
    cam_write(9, 24'h0F0F0F, 1'b0, 1'b0);
    #2;
    reset_and_init("init2");
    cam_cmp(24'h111111);
    chk("rst_a5_gone", NE'(match), NE'(0));
    cam_cmp(24'h0F0F0F);
    chk("rst_a9_gone", NE'(match), NE'(0));

    // Edge entries: address 0 with key 0, and the top address with all-ones.
    cam_write(0,   24'h000000, 1'b0, 1'b1);
    cam_write(511, 24'hFFFFFF, 1'b0, 1'b1);
    cam_cmp(24'h000000);
    chk("a0_match", NE'(match),      NE'(1));
    chk("a0_many",  match_many,      NE'(1));
    chk("a0_addr",  NE'(match_addr), '0);
    cam_cmp(24'hFFFFFF);
    chk("a511_many", match_many,      NE'(1) << 511);
    chk("a511_addr", NE'(match_addr), PE ? NE'(511) : '0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests %0d failures %0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
